vedic_mul_seq_ctrl: RTL

Sequential WIDTH×WIDTH unsigned multiplier controller that time-multiplexes a single instance of the team's 2-bit Vedic multiplier core (`multip_2bit`: ports `a[1:0]`, `b[1:0]`, `q[3:0]`). It splits both operands into 2-bit digits, feeds one digit pair to the core per cycle, and accumulates the shifted partial products. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. This gives area-cheap wide multiplication from the existing 2-bit datapath.

---
 rtl/vedic_mul_seq_ctrl_if.sv | 24 ++
 rtl/vedic_mul_seq_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/vedic_mul_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential Vedic multiplier controller.
// master = producer/consumer side, slave = controller side.
interface vedic_mul_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/vedic_mul_seq_ctrl.sv
// WIDTH x WIDTH unsigned multiplier time-multiplexing one 2-bit Vedic core.
// Optional macro VEDIC_SEQ_ZERO_SKIP_EN: zero operands bypass CALC straight to DONE.

module multip_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] q
);
  logic w_p0, w_p1, w_p2, w_p3, w_c;
  assign w_p0 = a[0] & b[0];
  assign w_p1 = a[1] & b[0];
  assign w_p2 = a[0] & b[1];
  assign w_p3 = a[1] & b[1];
  assign w_c  = w_p1 & w_p2;
  assign q    = {w_p3 & w_c, w_p3 ^ w_c, w_p1 ^ w_p2, w_p0};
endmodule

// state  | meaning
// S_IDLE | waiting for an operand pair, in_ready high
// S_CALC | one digit pair per cycle accumulated into r_acc
// S_DONE | product presented, waiting for out_ready
module vedic_mul_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  vedic_mul_seq_ctrl_if.slave bus
);
  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int SW = IW + 2;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [WIDTH-1:0]  r_a, r_b;
  logic [PW-1:0]     r_acc, r_product;
  logic [IW-1:0]     r_i, r_j;

  logic              w_accept, w_last, w_zero;
  logic [WIDTH-1:0]  w_a_sh, w_b_sh;
  logic [1:0]        w_core_a, w_core_b;
  logic [3:0]        w_q;
  logic [SW-1:0]     w_shift;
  logic [PW-1:0]     w_pp, w_acc_nxt;

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
  assign w_zero = (bus.a_in == '0) || (bus.b_in == '0);
`else
  assign w_zero = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_last   = (r_i == LAST) && (r_j == LAST);

  // Shifting rather than part-selecting keeps the digit pick legal for WIDTH=2.
  assign w_a_sh   = r_a >> {r_i, 1'b0};
  assign w_b_sh   = r_b >> {r_j, 1'b0};
  assign w_core_a = (r_state == S_CALC) ? w_a_sh[1:0] : 2'b00;
  assign w_core_b = (r_state == S_CALC) ? w_b_sh[1:0] : 2'b00;

  multip_2bit u_core (
    .a (w_core_a),
    .b (w_core_b),
    .q (w_q)
  );

  assign w_shift   = SW'({r_i, 1'b0}) + SW'({r_j, 1'b0});
  assign w_pp      = PW'(w_q) << w_shift;
  assign w_acc_nxt = r_acc + w_pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.in_valid) w_next = w_zero ? S_DONE : S_CALC;
      S_CALC: if (w_last)       w_next = S_DONE;
      S_DONE: if (bus.out_ready) w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_i       <= '0;
      r_j       <= '0;
    end else if (w_accept) begin
      r_a   <= bus.a_in;
      r_b   <= bus.b_in;
      r_acc <= '0;
      r_i   <= '0;
      r_j   <= '0;
      if (w_zero) r_product <= '0;
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_nxt;
      if (w_last) r_product <= w_acc_nxt;
      if (r_j == LAST) begin
        r_j <= '0;
        r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
      end else begin
        r_j <= r_j + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_CALC);
  assign bus.product   = r_product;
endmodule
